// File: rtl/fifo_16.sv
// 16-entry x 32-bit show-ahead FIFO; head word is selected from discrete registers by a 16:1 mux.
// Optional sticky overflow/underflow outputs are enabled by defining FIFO_ERR_EN.

module mux_16 (
  input  logic [15:0][31:0] data_i,
  input  logic [3:0]        sel_i,
  output logic [31:0]       data_o
);

  assign data_o = data_i[sel_i];

endmodule

module fifo_16 #(
  parameter int AFULL_LEVEL  = 12,
  parameter int AEMPTY_LEVEL = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        full,
  output logic        empty,
  output logic        almost_full,
  output logic        almost_empty,
  output logic [4:0]  count
`ifdef FIFO_ERR_EN
  ,
  output logic        overflow,
  output logic        underflow
`endif
);

  localparam logic [4:0] AFULL_LVL_C  = 5'(AFULL_LEVEL);
  localparam logic [4:0] AEMPTY_LVL_C = 5'(AEMPTY_LEVEL);

  logic [15:0][31:0] mem_q;
  logic [3:0]        wr_ptr_q;
  logic [3:0]        rd_ptr_q;
  logic [4:0]        count_q;
  logic [4:0]        count_d;
  logic              wr_acc;
  logic              rd_acc;

  // Count is authoritative for every flag; pointer equality is never consulted.
  assign full         = (count_q == 5'd16);
  assign empty        = (count_q == 5'd0);
  assign almost_full  = (count_q >= AFULL_LVL_C);
  assign almost_empty = (count_q <= AEMPTY_LVL_C);
  assign count        = count_q;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  mux_16 u_head_mux (
    .data_i (mem_q),
    .sel_i  (rd_ptr_q),
    .data_o (rd_data)
  );

  always_comb begin
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= 4'd0;
      rd_ptr_q <= 4'd0;
      count_q  <= 5'd0;
    end else begin
      if (wr_acc) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + 4'd1;
      end
      if (rd_acc) begin
        rd_ptr_q <= rd_ptr_q + 4'd1;
      end
      count_q <= count_d;
    end
  end

`ifdef FIFO_ERR_EN
  logic overflow_q;
  logic underflow_q;

  // Sticky error flags; only reset clears them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en && full) begin
        overflow_q <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_16.sv
// Directed bench for fifo_16 with a queue scoreboard of expected head words.

module tb_fifo_16;

  logic        clock;
  logic        reset;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [4:0]  count;
`ifdef FIFO_ERR_EN
  logic        overflow;
  logic        underflow;
`endif

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb_q[$];

  fifo_16 dut (
    .clock        (clock),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count)
`ifdef FIFO_ERR_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    n = sb_q.size();
    chk({tag, ":count"},  32'(count),        32'(n));
    chk({tag, ":empty"},  32'(empty),        32'(n == 0));
    chk({tag, ":full"},   32'(full),         32'(n == 16));
    chk({tag, ":afull"},  32'(almost_full),  32'(n >= 12));
    chk({tag, ":aempty"}, 32'(almost_empty), 32'(n <= 4));
    if (n > 0) chk({tag, ":head"}, rd_data, sb_q[0]);
  endtask

  // One clock cycle: drive, check popped head before the edge, update model, check after.
  task automatic cycle(input string tag, input logic w, input logic [31:0] wd, input logic r);
    int n;
    n = sb_q.size();
    wr_en   = w;
    wr_data = wd;
    rd_en   = r;
    #1;
    if (r && n > 0) chk({tag, ":pop"}, rd_data, sb_q[0]);
    @(posedge clock);
    if (r && n > 0) void'(sb_q.pop_front());
    if (w && n < 16) sb_q.push_back(wd);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_state(tag);
  endtask

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_state("reset");
    chk("reset:rd_data", rd_data, 32'h0000_0000);

    for (int i = 1; i <= 16; i++) cycle("fill", 1'b1, 32'(i), 1'b0);

    cycle("ovf_wr", 1'b1, 32'hDEAD_BEEF, 1'b0);
    cycle("ovf_wr_rd", 1'b1, 32'hBAAD_F00D, 1'b1);
`ifdef FIFO_ERR_EN
    chk("overflow", 32'(overflow), 32'd1);
`endif
    for (int i = 0; i < 15; i++) cycle("drain", 1'b0, 32'd0, 1'b1);
    chk("drain:empty", 32'(empty), 32'd1);

    for (int i = 0; i < 10; i++) cycle("pre_w", 1'b1, 32'h100 + 32'(i), 1'b0);
    for (int i = 0; i < 10; i++) cycle("pre_r", 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 10; i++) cycle("wrap_w", 1'b1, 32'hA0 + 32'(i), 1'b0);
    for (int i = 0; i < 10; i++) cycle("wrap_r", 1'b0, 32'd0, 1'b1);
    chk("wrap:count", 32'(count), 32'd0);

    cycle("empty_rd", 1'b0, 32'd0, 1'b1);
    cycle("empty_rw", 1'b1, 32'h77, 1'b1);
    chk("empty_rw:rd_data", rd_data, 32'h77);
`ifdef FIFO_ERR_EN
    chk("underflow", 32'(underflow), 32'd1);
`endif
    cycle("pop77", 1'b0, 32'd0, 1'b1);
    cycle("push55", 1'b1, 32'h55, 1'b0);
    cycle("one_rw", 1'b1, 32'h66, 1'b1);
    chk("one_rw:rd_data", rd_data, 32'h66);
    chk("one_rw:count", 32'(count), 32'd1);
    cycle("pop66", 1'b0, 32'd0, 1'b1);

    for (int i = 0; i < 7; i++) cycle("mid_w", 1'b1, 32'h300 + 32'(i), 1'b0);
    chk("mid:count", 32'(count), 32'd7);
    reset = 1'b1;
    #1;
    sb_q.delete();
    check_state("async_rst");
    chk("async_rst:rd_data", rd_data, 32'h0000_0000);
`ifdef FIFO_ERR_EN
    chk("async_rst:overflow", 32'(overflow), 32'd0);
    chk("async_rst:underflow", 32'(underflow), 32'd0);
`endif
    @(posedge clock);
    #1;
    reset = 1'b0;
    cycle("post_rst_w", 1'b1, 32'h99, 1'b0);
    chk("post_rst:rd_data", rd_data, 32'h99);
    chk("post_rst:count", 32'(count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_16.md
Name: fifo_16

Overview:
- 16-entry × 32-bit synchronous FIFO for the processor datapath, e.g. buffering memory/IO words between producer and consumer stages.
- Storage is 16 discrete 32-bit registers. The read pointer drives the 4-bit select of a 16:1 32-bit word mux (mux_16), whose output is rd_data.
- Show-ahead (first-word-fall-through) read: the head word is visible whenever the FIFO is non-empty.

Parameters:
- AFULL_LEVEL, 12: almost_full asserts when count >= AFULL_LEVEL (valid range 1..16).
- AEMPTY_LEVEL, 4: almost_empty asserts when count <= AEMPTY_LEVEL (valid range 0..15).

Ports:
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  write request.
- wr_data  input  32  word to enqueue.
- rd_en  input  1  read/pop request.
- rd_data  output  32  head word, equal to mem[rd_ptr] via the 16:1 mux.
- full  output  1  count == 16.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_LEVEL.
- almost_empty  output  1  count <= AEMPTY_LEVEL.
- count  output  5  occupancy, 0..16.

Behaviour:
- Reset (asynchronous, immediate):
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - All 16 storage registers = 0, so rd_data = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
- Reset asserted mid-operation discards all contents; the first write after reset deassertion lands in entry 0.
- Write accept: wr_acc = wr_en & ~full, using full as registered before the edge.
  - On accept: mem[wr_ptr] <= wr_data; wr_ptr <= wr_ptr + 1 (4-bit, wraps 15 -> 0).
- Read accept: rd_acc = rd_en & ~empty.
  - On accept: rd_ptr <= rd_ptr + 1 (wraps 15 -> 0).
  - rd_data is combinational from rd_ptr. It shows the current head during the cycle and the next head after the edge.
- Count update:
  - +1 if wr_acc only.
  - -1 if rd_acc only.
  - Unchanged if both or neither.
- Flags are combinational decodes of count; no extra latency.
- Latency: a word written at edge N is visible on rd_data after edge N when the FIFO was empty before. Write-to-read latency is 1 cycle.
- Full boundary: a write while full is dropped, even if rd_en is also high that cycle. The read proceeds and count goes 16 -> 15. Storage and wr_ptr are untouched by the dropped write.
- Empty boundary: a read while empty is ignored; rd_ptr and count are unchanged. A simultaneous write is accepted and count goes 0 -> 1.
- Simultaneous read and write with 0 < count < 16: both pointers advance and count is unchanged.
  - When count == 1, the head word is popped and the new word becomes the head after the edge.
- Pointer equality alone never determines full/empty; count is authoritative.
- No X propagation: rd_data always reflects a defined register value.

Optional Feature:
- Macro FIFO_ERR_EN.
- When defined, two extra output ports are present:
  - overflow (1 bit): sticky; sets on any cycle with wr_en & full.
  - underflow (1 bit): sticky; sets on any cycle with rd_en & empty.
  - Both clear only on reset and reset to 0.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset, then idle 3 cycles -> empty=1, full=0, count=0, rd_data=0x00000000, almost_empty=1.
- Write 0x00000001..0x00000010 (16 writes, back to back) -> count steps 1..16. full=1 after the 16th edge. almost_full rises after the 12th write. rd_data=0x00000001 throughout.
- With FIFO full, write 0xDEADBEEF -> count stays 16. Draining 16 reads yields 0x01..0x10 in order with no 0xDEADBEEF. empty=1 at the end. overflow=1 if FIFO_ERR_EN is defined.
- Wrap: write 10 words, read 10, then write 0xA0..0xA9 and read all -> the pointers wrap past 15 and the data returns in order 0xA0..0xA9. count returns to 0.
- Simultaneous read and write:
  - With count=1, head=0x55: rd_en=wr_en=1, wr_data=0x66 -> next cycle count=1, rd_data=0x66.
  - With count=0: rd_en=wr_en=1, wr_data=0x77 -> count=1, rd_data=0x77. underflow stays 0 only if rd_en is not sampled while empty; it sets here when FIFO_ERR_EN is defined.
- Reset mid-stream with count=7 -> outputs return to reset values immediately, before the next clock edge. A following write of 0x99 then gives rd_data=0x99, count=1.
